// File: rtl/alu_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_if
// Client-side bundle of the shared-ALU controller: two request channels
// (valid/ready with operands and opcode), two one-cycle response strobes and
// the shared captured result.
//   master : seen from the clients (drive requests, receive responses)
//   slave  : seen from the controller
// ---------------------------------------------------------------------------
interface alu_share_ctrl_if #(
   parameter int nIO = 8
);
   logic           REQ0_VALID;
   logic           REQ1_VALID;
   logic           REQ0_READY;
   logic           REQ1_READY;
   logic [nIO-1:0] REQ0_A;
   logic [nIO-1:0] REQ0_B;
   logic [nIO-1:0] REQ1_A;
   logic [nIO-1:0] REQ1_B;
   logic [2:0]     REQ0_OP;
   logic [2:0]     REQ1_OP;
   logic           RSP0_VALID;
   logic           RSP1_VALID;
   logic [nIO-1:0] RSP_Z;
   logic           RSP_OV;

   modport master (
      output REQ0_VALID, REQ1_VALID,
      output REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_OP, REQ1_OP,
      input  REQ0_READY, REQ1_READY,
      input  RSP0_VALID, RSP1_VALID, RSP_Z, RSP_OV
   );

   modport slave (
      input  REQ0_VALID, REQ1_VALID,
      input  REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_OP, REQ1_OP,
      output REQ0_READY, REQ1_READY,
      output RSP0_VALID, RSP1_VALID, RSP_Z, RSP_OV
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one combinational ALU between two clients. Requests are arbitrated
// round-robin, operands are registered onto the ALU, held for SETTLE cycles,
// then Z/OV are captured and returned with a one-cycle strobe to the owner.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : request/response channels of both clients
//   BUSY            : high in every state except IDLE
//   ALU_A/B/OP      : registered operands/opcode to the ALU
//   ALU_Z/OV        : ALU result and overflow
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate, accept one request, load ALU operands
// EXEC  | operands held on the ALU; counter runs down to capture
// DONE  | result registered; strobe RSP(owner)_VALID for one cycle
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int nIO    = 8,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_ctrl_if.slave    bus,
   output logic               BUSY,
   output logic [nIO-1:0]     ALU_A,
   output logic [nIO-1:0]     ALU_B,
   output logic [2:0]         ALU_OP,
   input  logic [nIO-1:0]     ALU_Z,
   input  logic               ALU_OV
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t         state_q, state_d;
   logic           last_q, last_d;
   logic           owner_q, owner_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [nIO-1:0] alu_a_q, alu_a_d;
   logic [nIO-1:0] alu_b_q, alu_b_d;
   logic [2:0]     alu_op_q, alu_op_d;
   logic [nIO-1:0] rsp_z_q, rsp_z_d;
   logic           rsp_ov_q, rsp_ov_d;

   logic           grant;
   logic           any_valid;
   logic           accept;

   // On a tie the client that was not served last wins.
   always_comb begin
      any_valid = bus.REQ0_VALID | bus.REQ1_VALID;
      grant     = 1'b0;
      if (bus.REQ0_VALID && bus.REQ1_VALID) begin
         grant = ~last_q;
      end else if (bus.REQ1_VALID) begin
         grant = 1'b1;
      end
   end

   // Gating with rst_n keeps READY low while reset is held even if a client
   // is already presenting a request.
   assign accept         = rst_n && (state_q == ST_IDLE) && any_valid;
   assign bus.REQ0_READY = accept && !grant;
   assign bus.REQ1_READY = accept && grant;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      rsp_z_d  = rsp_z_q;
      rsp_ov_d = rsp_ov_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               alu_a_d  = grant ? bus.REQ1_A  : bus.REQ0_A;
               alu_b_d  = grant ? bus.REQ1_B  : bus.REQ0_B;
               alu_op_d = grant ? bus.REQ1_OP : bus.REQ0_OP;
               owner_d  = grant;
               last_d   = grant;
               cnt_d    = SETTLE_M1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               rsp_z_d  = ALU_Z;
               rsp_ov_d = ALU_OV;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         cnt_q    <= 4'd0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= 3'd0;
         rsp_z_q  <= '0;
         rsp_ov_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         rsp_z_q  <= rsp_z_d;
         rsp_ov_q <= rsp_ov_d;
      end
   end

   assign BUSY           = (state_q != ST_IDLE);
   assign bus.RSP0_VALID = (state_q == ST_DONE) && !owner_q;
   assign bus.RSP1_VALID = (state_q == ST_DONE) && owner_q;
   assign bus.RSP_Z      = rsp_z_q;
   assign bus.RSP_OV     = rsp_ov_q;
   assign ALU_A          = alu_a_q;
   assign ALU_B          = alu_b_q;
   assign ALU_OP         = alu_op_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Two controller instances (SETTLE=1 and SETTLE=4) share clock and reset;
// each drives its own behavioural ALU. Expected responses are queued at
// accept time and checked by a monitor when a response strobe appears.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
   localparam int NIO = 8;

   typedef struct {
      logic       cl;
      logic [7:0] z;
      logic       ov;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   exp_t sb1[$];
   exp_t sb4[$];

   logic       req_v  [2][2];
   logic [7:0] req_a  [2][2];
   logic [7:0] req_b  [2][2];
   logic [2:0] req_op [2][2];
   logic       rdy    [2][2];
   logic       rsp_v  [2][2];
   logic [7:0] rsp_z  [2];
   logic       rsp_ov [2];
   logic       busy   [2];
   logic [7:0] alu_a  [2];
   logic [7:0] alu_b  [2];
   logic [2:0] alu_op [2];
   logic [7:0] alu_z  [2];
   logic       alu_ov [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
      logic [7:0] z;
      logic       ov;
      z  = '0;
      ov = 1'b0;
      case (op)
         3'b000: begin z = a + b; ov = (a[7] == b[7]) && (z[7] != a[7]); end
         3'b001: begin z = a - b; ov = (a[7] != b[7]) && (z[7] != a[7]); end
         3'b010: z = a & b;
         3'b011: z = a | b;
         default: z = a ^ b;
      endcase
      return {ov, z};
   endfunction

   for (genvar gd = 0; gd < 2; gd++) begin : g_dut
      alu_share_ctrl_if #(.nIO(NIO)) bus ();

      assign bus.REQ0_VALID = req_v[gd][0];
      assign bus.REQ1_VALID = req_v[gd][1];
      assign bus.REQ0_A     = req_a[gd][0];
      assign bus.REQ0_B     = req_b[gd][0];
      assign bus.REQ1_A     = req_a[gd][1];
      assign bus.REQ1_B     = req_b[gd][1];
      assign bus.REQ0_OP    = req_op[gd][0];
      assign bus.REQ1_OP    = req_op[gd][1];
      assign rdy[gd][0]     = bus.REQ0_READY;
      assign rdy[gd][1]     = bus.REQ1_READY;
      assign rsp_v[gd][0]   = bus.RSP0_VALID;
      assign rsp_v[gd][1]   = bus.RSP1_VALID;
      assign rsp_z[gd]      = bus.RSP_Z;
      assign rsp_ov[gd]     = bus.RSP_OV;
      assign {alu_ov[gd], alu_z[gd]} = alu_fn(alu_a[gd], alu_b[gd], alu_op[gd]);

      alu_share_ctrl #(.nIO(NIO), .SETTLE(gd == 0 ? 1 : 4)) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .bus    (bus),
         .BUSY   (busy[gd]),
         .ALU_A  (alu_a[gd]),
         .ALU_B  (alu_b[gd]),
         .ALU_OP (alu_op[gd]),
         .ALU_Z  (alu_z[gd]),
         .ALU_OV (alu_ov[gd])
      );
   end

   // Scoreboard monitor: every response strobe must match the oldest queued
   // expectation of that instance.
   always @(negedge clk) begin
      exp_t e;
      logic empty;
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (rsp_v[d][0] || rsp_v[d][1]) begin
               n_cmp++;
               empty = (d == 0) ? (sb1.size() == 0) : (sb4.size() == 0);
               if (empty) begin
                  n_fail++;
                  $display("FAIL rsp_unexpected dut%0d: got strobe %b%b with nothing outstanding",
                           d, rsp_v[d][1], rsp_v[d][0]);
               end else begin
                  e = (d == 0) ? sb1.pop_front() : sb4.pop_front();
                  if ({rsp_v[d][1], rsp_v[d][0]} !== (e.cl ? 2'b10 : 2'b01) ||
                      rsp_z[d] !== e.z || rsp_ov[d] !== e.ov) begin
                     n_fail++;
                     $display("FAIL rsp_data dut%0d: got strobe=%b%b z=%h ov=%b, expected client%0d z=%h ov=%b",
                              d, rsp_v[d][1], rsp_v[d][0], rsp_z[d], rsp_ov[d], e.cl, e.z, e.ov);
                  end
               end
            end
         end
      end
   end

   task automatic at_cyc(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic issue(input int d, input int cl, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] ez, input logic eov,
                        output int tr, output int ta);
      exp_t e;
      tr = -1;
      ta = -1;
      @(posedge clk); #1;
      req_a[d][cl]  = a;
      req_b[d][cl]  = b;
      req_op[d][cl] = op;
      req_v[d][cl]  = 1'b1;
      for (int k = 0; k < 40 && ta < 0; k++) begin
         @(negedge clk);
         if (k == 0) tr = cyc;
         if (rdy[d][cl]) begin
            ta   = cyc;
            e.cl = cl[0];
            e.z  = ez;
            e.ov = eov;
            if (d == 0) sb1.push_back(e); else sb4.push_back(e);
         end
      end
      n_cmp++;
      if (ta < 0) begin
         n_fail++;
         $display("FAIL accept_timeout dut%0d client%0d: not accepted within 40 cycles, required acceptance", d, cl);
      end
      @(posedge clk); #1;
      req_v[d][cl] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({rdy[d][0], rdy[d][1], rsp_v[d][0], rsp_v[d][1], busy[d], rsp_ov[d],
              rsp_z[d], alu_a[d], alu_b[d], alu_op[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: rdy=%b%b rsp=%b%b busy=%b ov=%b z=%h a=%h b=%h op=%h, required all 0",
                     d, rdy[d][1], rdy[d][0], rsp_v[d][1], rsp_v[d][0], busy[d], rsp_ov[d],
                     rsp_z[d], alu_a[d], alu_b[d], alu_op[d]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_sub();
      int tr, ta;
      issue(0, 0, 8'd5, 8'd3, 3'b001, 8'd2, 1'b0, tr, ta);
      n_cmp++;
      if (ta !== tr) begin
         n_fail++;
         $display("FAIL single_ready_first: accepted in cycle %0d, required %0d", ta, tr);
      end
      for (int k = 1; k <= 3; k++) begin
         at_cyc(ta + k);
         n_cmp++;
         if (rsp_v[0][0] !== (k == 2) || rsp_v[0][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_timing t+%0d: rsp0=%b rsp1=%b, required rsp0=%b rsp1=0",
                     k, rsp_v[0][0], rsp_v[0][1], (k == 2));
         end
         if (k == 2) begin
            n_cmp++;
            if (rsp_z[0] !== 8'd2 || rsp_ov[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL single_rsp_data: z=%h ov=%b, required z=02 ov=0", rsp_z[0], rsp_ov[0]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int tr, ta;
      issue(0, 1, 8'd100, 8'hCE, 3'b001, 8'h96, 1'b1, tr, ta);
      for (int k = 1; k <= 3; k++) begin
         at_cyc(ta + k);
         n_cmp++;
         if (rsp_v[0][1] !== (k == 2) || rsp_v[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pulse t+%0d: rsp1=%b rsp0=%b, required rsp1=%b rsp0=0",
                     k, rsp_v[0][1], rsp_v[0][0], (k == 2));
         end
      end
      n_cmp++;
      if (rsp_z[0] !== 8'b1001_0110 || rsp_ov[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_hold: z=%h ov=%b, required z=96 ov=1", rsp_z[0], rsp_ov[0]);
      end
   endtask

   task automatic test_tie();
      logic [7:0] ta_tab [2][2];
      logic [7:0] tb_tab [2][2];
      logic [7:0] tz_tab [2][2];
      logic       tov_tab[2][2];
      int   idx[2];
      int   g[4];
      int   tacc[4];
      int   n;
      int   upd;
      exp_t e;

      ta_tab[0][0] = 8'd10;  tb_tab[0][0] = 8'd4;   tz_tab[0][0] = 8'h06; tov_tab[0][0] = 1'b0;
      ta_tab[0][1] = 8'd20;  tb_tab[0][1] = 8'd7;   tz_tab[0][1] = 8'h0D; tov_tab[0][1] = 1'b0;
      ta_tab[1][0] = 8'hFD;  tb_tab[1][0] = 8'd9;   tz_tab[1][0] = 8'hF4; tov_tab[1][0] = 1'b0;
      ta_tab[1][1] = 8'h9C;  tb_tab[1][1] = 8'd100; tz_tab[1][1] = 8'h38; tov_tab[1][1] = 1'b1;
      idx[0] = 0;
      idx[1] = 0;
      n = 0;

      @(posedge clk); #1;
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         req_a[0][c]  = ta_tab[c][0];
         req_b[0][c]  = tb_tab[c][0];
         req_op[0][c] = 3'b001;
         req_v[0][c]  = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if (rdy[0][0] !== 1'b0 || rdy[0][1] !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_ready_in_reset: rdy0=%b rdy1=%b, required 0 0", rdy[0][0], rdy[0][1]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int k = 0; k < 30 && n < 4; k++) begin
         @(negedge clk);
         upd = -1;
         n_cmp++;
         if (rdy[0][0] && rdy[0][1]) begin
            n_fail++;
            $display("FAIL tie_one_ready: rdy0=1 rdy1=1, required at most one");
         end
         if (rdy[0][0] || rdy[0][1]) begin
            upd     = rdy[0][1] ? 1 : 0;
            g[n]    = upd;
            tacc[n] = cyc;
            e.cl    = upd[0];
            e.z     = tz_tab[upd][idx[upd]];
            e.ov    = tov_tab[upd][idx[upd]];
            sb1.push_back(e);
            n++;
         end
         @(posedge clk); #1;
         if (upd >= 0) begin
            idx[upd]++;
            if (idx[upd] == 2) begin
               req_v[0][upd] = 1'b0;
            end else begin
               req_a[0][upd] = ta_tab[upd][idx[upd]];
               req_b[0][upd] = tb_tab[upd][idx[upd]];
            end
         end
      end

      n_cmp++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL tie_count: %0d accepts, required 4", n);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (g[i] != (i % 2)) begin
               n_fail++;
               $display("FAIL tie_order op%0d: granted client%0d, required client%0d", i, g[i], i % 2);
            end
         end
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (tacc[i + 1] - tacc[i] != 3) begin
               n_fail++;
               $display("FAIL tie_spacing op%0d: accept gap %0d, required 3", i, tacc[i + 1] - tacc[i]);
            end
         end
      end
      for (int k = 0; k < 10 && sb1.size() != 0; k++) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int tr, ta, a1;
      exp_t e;
      a1 = -1;
      issue(0, 0, 8'd1, 8'd2, 3'b000, 8'd3, 1'b0, tr, ta);
      req_a[0][1]  = 8'hF9;
      req_b[0][1]  = 8'd33;
      req_op[0][1] = 3'b001;
      req_v[0][1]  = 1'b1;
      for (int k = 0; k < 10 && a1 < 0; k++) begin
         @(negedge clk);
         if (rdy[0][1]) begin
            a1   = cyc;
            e.cl = 1'b1;
            e.z  = 8'hD8;
            e.ov = 1'b0;
            sb1.push_back(e);
         end
      end
      n_cmp++;
      if (a1 != ta + 3) begin
         n_fail++;
         $display("FAIL bp_accept_cycle: client1 accepted at %0d, required %0d", a1, ta + 3);
      end
      @(posedge clk); #1;
      req_v[0][1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (alu_a[0] !== 8'hF9 || alu_b[0] !== 8'd33 || alu_op[0] !== 3'b001) begin
         n_fail++;
         $display("FAIL bp_operands: a=%h b=%h op=%h, required a=f9 b=21 op=1", alu_a[0], alu_b[0], alu_op[0]);
      end
      for (int k = 0; k < 10 && sb1.size() != 0; k++) @(negedge clk);
   endtask

   task automatic test_settle();
      int tr, ta, nbusy;
      nbusy = 0;
      issue(1, 0, 8'd10, 8'd7, 3'b001, 8'd3, 1'b0, tr, ta);
      for (int k = 1; k <= 6; k++) begin
         at_cyc(ta + k);
         if (busy[1]) nbusy++;
         if (k <= 4) begin
            n_cmp++;
            if (alu_a[1] !== 8'd10 || alu_b[1] !== 8'd7) begin
               n_fail++;
               $display("FAIL settle_operands t+%0d: a=%h b=%h, required a=0a b=07", k, alu_a[1], alu_b[1]);
            end
         end
         if (k == 5) begin
            n_cmp++;
            if (rsp_v[1][0] !== 1'b1 || rsp_z[1] !== 8'd3 || rsp_ov[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL settle_rsp t+5: rsp0=%b z=%h ov=%b, required rsp0=1 z=03 ov=0",
                        rsp_v[1][0], rsp_z[1], rsp_ov[1]);
            end
         end
      end
      n_cmp++;
      if (nbusy != 5) begin
         n_fail++;
         $display("FAIL settle_busy_len: busy %0d cycles, required 5", nbusy);
      end
   endtask

   task automatic test_reset_mid_op();
      int tr, ta, tr2, ta2;
      issue(1, 0, 8'd1, 8'd1, 3'b000, 8'd2, 1'b0, tr, ta);
      if (sb4.size() != 0) void'(sb4.pop_back());
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy[1], rsp_v[1][0], rsp_v[1][1], rdy[1][0], rdy[1][1], rsp_ov[1],
           rsp_z[1], alu_a[1], alu_b[1], alu_op[1]} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: busy=%b rsp=%b%b z=%h ov=%b a=%h b=%h op=%h, required all 0",
                  busy[1], rsp_v[1][1], rsp_v[1][0], rsp_z[1], rsp_ov[1], alu_a[1], alu_b[1], alu_op[1]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(1, 0, 8'h80, 8'h01, 3'b001, 8'h7F, 1'b1, tr2, ta2);
      at_cyc(ta2 + 5);
      n_cmp++;
      if (rsp_v[1][0] !== 1'b1 || rsp_z[1] !== 8'h7F || rsp_ov[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_fresh_op: rsp0=%b z=%h ov=%b, required rsp0=1 z=7f ov=1",
                  rsp_v[1][0], rsp_z[1], rsp_ov[1]);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            req_v[d][c]  = 1'b0;
            req_a[d][c]  = '0;
            req_b[d][c]  = '0;
            req_op[d][c] = '0;
         end
      end

      test_reset();
      test_single_sub();
      test_overflow();
      test_tie();
      test_backpressure();
      test_settle();
      test_reset_mid_op();

      repeat (4) @(negedge clk);
      n_cmp++;
      if (sb1.size() != 0 || sb4.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", sb1.size(), sb4.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
